// File: rtl/as_rx_cfg.sv
// as_rx_cfg: oversampling asynchronous serial receiver with runtime-selectable
// parity mode and stop-bit count, majority-vote bit sampling and a
// valid/ready output holding register that drops (and flags) frames the
// consumer has not made room for.
module as_rx_cfg #(
    parameter int DATA_W = 8,
    parameter int OVS    = 16,
    parameter int DIV_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              rx_i,
    input  logic [DIV_W-1:0]  div_i,
    input  logic [1:0]        parity_i,
    input  logic              stop2_i,
    input  logic              ready_i,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o,
    output logic              parity_err_o,
    output logic              frame_err_o,
    output logic              overrun_o,
    output logic              busy_o
);

    localparam int TICK_W = $clog2(OVS);
    localparam int BIT_W  = $clog2(DATA_W);

    // Tick positions inside one bit: three votes around the bit centre.
    localparam logic [TICK_W-1:0] TICK_LO   = TICK_W'(OVS / 2 - 1);
    localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(OVS / 2);
    localparam logic [TICK_W-1:0] TICK_HI   = TICK_W'(OVS / 2 + 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVS - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);

    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    // Two-of-three vote used for every bit decision.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // XOR reduction of a received word (even-parity sum).
    function automatic logic word_parity(input logic [DATA_W-1:0] w);
        return ^w;
    endfunction

    state_t              state_r;
    state_t              state_next_s;

    logic                rx_meta_r;
    logic                rx_sync_r;
    logic                rx_prev_r;
    logic                fall_s;

    logic [DIV_W-1:0]    div_cnt_r;
    logic                tick_s;
    logic [TICK_W-1:0]   tick_cnt_r;
    logic                at_lo_s;
    logic                at_mid_s;
    logic                at_hi_s;
    logic                at_end_s;

    logic                samp_lo_r;
    logic                samp_mid_r;
    logic                maj_s;

    logic [BIT_W-1:0]    bit_cnt_r;
    logic [DATA_W-1:0]   shift_r;
    logic [1:0]          par_mode_r;
    logic                stop2_r;
    logic                stop_idx_r;
    logic                par_err_r;
    logic                stop_err_r;
    logic                par_en_s;
    logic                complete_s;

    logic [DATA_W-1:0]   data_r;
    logic                valid_r;
    logic                parity_err_r;
    logic                frame_err_r;
    logic                overrun_r;
    logic                busy_r;

    assign fall_s   = rx_prev_r & ~rx_sync_r;
    assign tick_s   = (state_r != ST_IDLE) && (div_cnt_r >= div_i);
    assign at_lo_s  = tick_s && (tick_cnt_r == TICK_LO);
    assign at_mid_s = tick_s && (tick_cnt_r == TICK_MID);
    assign at_hi_s  = tick_s && (tick_cnt_r == TICK_HI);
    assign at_end_s = tick_s && (tick_cnt_r == TICK_LAST);
    assign maj_s    = maj3(samp_lo_r, samp_mid_r, rx_sync_r);
    assign par_en_s = (par_mode_r == PAR_EVEN) || (par_mode_r == PAR_ODD);

    // Synchronise the serial line and keep one extra stage for edge detection.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
            rx_prev_r <= 1'b1;
        end else begin
            rx_meta_r <= rx_i;
            rx_sync_r <= rx_meta_r;
            rx_prev_r <= rx_sync_r;
        end
    end

    // Oversample tick divider: parked at zero while idle, free-running in a frame.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_cnt_r <= '0;
        end else if (state_r == ST_IDLE) begin
            div_cnt_r <= '0;
        end else if (div_cnt_r >= div_i) begin
            div_cnt_r <= '0;
        end else begin
            div_cnt_r <= div_cnt_r + DIV_W'(1);
        end
    end

    // Tick position within the current bit.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tick_cnt_r <= '0;
        end else if (state_r == ST_IDLE) begin
            tick_cnt_r <= '0;
        end else if (tick_s) begin
            if (tick_cnt_r == TICK_LAST) begin
                tick_cnt_r <= '0;
            end else begin
                tick_cnt_r <= tick_cnt_r + TICK_W'(1);
            end
        end else begin
            tick_cnt_r <= tick_cnt_r;
        end
    end

    // Capture the first two votes; the third is the live synchronised line.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            samp_lo_r  <= 1'b1;
            samp_mid_r <= 1'b1;
        end else begin
            if (at_lo_s) begin
                samp_lo_r <= rx_sync_r;
            end
            if (at_mid_s) begin
                samp_mid_r <= rx_sync_r;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic and frame-completion strobe.
    always_comb begin
        state_next_s = state_r;
        complete_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (fall_s) begin
                    state_next_s = ST_START;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (at_hi_s && maj_s) begin
                    state_next_s = ST_IDLE;
                end else if (at_end_s) begin
                    state_next_s = ST_DATA;
                end else begin
                    state_next_s = ST_START;
                end
            end
            ST_DATA: begin
                if (at_end_s && (bit_cnt_r == BIT_LAST)) begin
                    if (par_en_s) begin
                        state_next_s = ST_PARITY;
                    end else begin
                        state_next_s = ST_STOP;
                    end
                end else begin
                    state_next_s = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (at_end_s) begin
                    state_next_s = ST_STOP;
                end else begin
                    state_next_s = ST_PARITY;
                end
            end
            ST_STOP: begin
                // The frame finishes at the centre of the final stop bit so a
                // back-to-back start bit is never missed.
                if (at_hi_s && (!stop2_r || stop_idx_r)) begin
                    complete_s   = 1'b1;
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_STOP;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Per-frame datapath: configuration snapshot, shifter, counters, error accumulation.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            par_mode_r <= 2'b00;
            stop2_r    <= 1'b0;
            bit_cnt_r  <= '0;
            stop_idx_r <= 1'b0;
            par_err_r  <= 1'b0;
            stop_err_r <= 1'b0;
            shift_r    <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (fall_s) begin
                        par_mode_r <= parity_i;
                        stop2_r    <= stop2_i;
                        bit_cnt_r  <= '0;
                        stop_idx_r <= 1'b0;
                        par_err_r  <= 1'b0;
                        stop_err_r <= 1'b0;
                    end
                end
                ST_DATA: begin
                    if (at_hi_s) begin
                        shift_r <= {maj_s, shift_r[DATA_W-1:1]};
                    end
                    if (at_end_s) begin
                        if (bit_cnt_r == BIT_LAST) begin
                            bit_cnt_r <= '0;
                        end else begin
                            bit_cnt_r <= bit_cnt_r + BIT_W'(1);
                        end
                    end
                end
                ST_PARITY: begin
                    if (at_hi_s) begin
                        par_err_r <= (word_parity(shift_r) ^ maj_s) != (par_mode_r == PAR_ODD);
                    end
                end
                ST_STOP: begin
                    if (at_hi_s && !maj_s) begin
                        stop_err_r <= 1'b1;
                    end
                    if (at_end_s) begin
                        stop_idx_r <= 1'b1;
                    end
                end
                default: begin
                    stop_idx_r <= stop_idx_r;
                end
            endcase
        end
    end

    // Output holding register with valid/ready handshake and overrun pulse.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_r       <= '0;
            valid_r      <= 1'b0;
            parity_err_r <= 1'b0;
            frame_err_r  <= 1'b0;
            overrun_r    <= 1'b0;
        end else begin
            overrun_r <= 1'b0;
            if (complete_s && (!valid_r || ready_i)) begin
                data_r       <= shift_r;
                parity_err_r <= par_err_r;
                frame_err_r  <= stop_err_r | ~maj_s;
                valid_r      <= 1'b1;
            end else if (complete_s) begin
                overrun_r <= 1'b1;
            end else if (ready_i) begin
                valid_r <= 1'b0;
            end else begin
                valid_r <= valid_r;
            end
        end
    end

    // Busy flag registered from the next state so it tracks the state register exactly.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_r <= 1'b0;
        end else begin
            busy_r <= (state_next_s != ST_IDLE);
        end
    end

    assign data_o       = data_r;
    assign valid_o      = valid_r;
    assign parity_err_o = parity_err_r;
    assign frame_err_o  = frame_err_r;
    assign overrun_o    = overrun_r;
    assign busy_o       = busy_r;

endmodule

// File: tb/tb_as_rx_cfg.sv
// tb_as_rx_cfg: directed and randomised frames against a frame-level model
// of the receiver (expected word/flags from the transmitted bits, plus a
// one-entry holding register for the handshake and overrun count).
module tb_as_rx_cfg;

    localparam int DATA_W = 8;
    localparam int OVS    = 16;
    localparam int DIV_W  = 16;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic              rx_i;
    logic [DIV_W-1:0]  div_i;
    logic [1:0]        parity_i;
    logic              stop2_i;
    logic              ready_i;
    logic [DATA_W-1:0] data_o;
    logic              valid_o;
    logic              parity_err_o;
    logic              frame_err_o;
    logic              overrun_o;
    logic              busy_o;

    int total = 0;
    int bad   = 0;
    int ovr_cnt = 0;
    int bit_clk = OVS;

    // frame-level reference model
    logic              m_valid;
    logic [DATA_W-1:0] m_data;
    logic              m_pe;
    logic              m_fe;
    int                m_ovr = 0;

    as_rx_cfg #(.DATA_W(DATA_W), .OVS(OVS), .DIV_W(DIV_W)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .rx_i(rx_i), .div_i(div_i),
        .parity_i(parity_i), .stop2_i(stop2_i), .ready_i(ready_i),
        .data_o(data_o), .valid_o(valid_o), .parity_err_o(parity_err_o),
        .frame_err_o(frame_err_o), .overrun_o(overrun_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    always @(negedge clk_i) begin
        if (overrun_o === 1'b1) ovr_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        @(negedge clk_i);
        check({tag, "_valid"}, 32'(valid_o), 32'(m_valid));
        check({tag, "_data"}, 32'(data_o), 32'(m_data));
        check({tag, "_perr"}, 32'(parity_err_o), 32'(m_pe));
        check({tag, "_ferr"}, 32'(frame_err_o), 32'(m_fe));
        check({tag, "_ovr"}, 32'(ovr_cnt), 32'(m_ovr));
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic send_bit(input logic b);
        rx_i = b;
        repeat (bit_clk) @(posedge clk_i);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic [1:0] pm, input logic s2,
                              input logic pbit, input logic sa, input logic sb);
        parity_i = pm;
        stop2_i  = s2;
        send_bit(1'b0);
        // configuration changes mid-frame must be ignored
        parity_i = 2'($urandom_range(0, 3));
        stop2_i  = 1'($urandom_range(0, 1));
        for (int i = 0; i < DATA_W; i++) send_bit(d[i]);
        if (pm == 2'b01 || pm == 2'b10) send_bit(pbit);
        send_bit(sa);
        if (s2) send_bit(sb);
        rx_i = 1'b1;
    endtask

    // Model: what the receiver should conclude about a transmitted frame.
    task automatic expect_frame(input logic [7:0] d, input logic [1:0] pm, input logic s2,
                                input logic pbit, input logic sa, input logic sb);
        int ones;
        logic pe;
        logic fe;
        ones = 0;
        for (int i = 0; i < DATA_W; i++) ones += int'(d[i]);
        ones += int'(pbit);
        if (pm == 2'b01)      pe = (ones % 2) != 0;
        else if (pm == 2'b10) pe = (ones % 2) != 1;
        else                  pe = 1'b0;
        fe = (sa == 1'b0) || (s2 && sb == 1'b0);
        if (!m_valid) begin
            m_valid = 1'b1;
            m_data  = d;
            m_pe    = pe;
            m_fe    = fe;
        end else begin
            m_ovr++;
        end
    endtask

    task automatic accept();
        ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        ready_i = 1'b0;
        m_valid = 1'b0;
    endtask

    initial begin
        logic [7:0] d;
        logic [1:0] pm;
        logic s2, pb, sa, sb;
        int dv;

        rst_ni = 1'b0; rx_i = 1'b1; div_i = '0; parity_i = 2'b00;
        stop2_i = 1'b0; ready_i = 1'b0;
        m_valid = 1'b0; m_data = '0; m_pe = 1'b0; m_fe = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_busy", 32'(busy_o), 32'd0);
        check_outputs("rst");
        rst_ni = 1'b1;
        idle(5);

        // short low glitch on an idle line: false start, no output
        rx_i = 1'b0;
        repeat (4) @(posedge clk_i);
        #1;
        check("glitch_busy_hi", 32'(busy_o), 32'd1);
        rx_i = 1'b1;
        idle(40);
        check("glitch_busy_lo", 32'(busy_o), 32'd0);
        check_outputs("glitch");

        // 0xA5, no parity, one stop bit, held until ready
        send_frame(8'hA5, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
        expect_frame(8'hA5, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
        idle(bit_clk);
        check_outputs("a5");
        idle(60);
        check_outputs("a5_hold");
        accept();
        check_outputs("a5_acc");

        // even parity, 0x03 with a wrong parity bit
        send_frame(8'h03, 2'b01, 1'b0, 1'b1, 1'b1, 1'b1);
        expect_frame(8'h03, 2'b01, 1'b0, 1'b1, 1'b1, 1'b1);
        idle(bit_clk);
        check_outputs("par03");
        accept();

        // two stop bits, second one low
        send_frame(8'h5A, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0);
        expect_frame(8'h5A, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0);
        rx_i = 1'b1;
        idle(2 * bit_clk);
        check_outputs("stop5a");
        accept();

        // two frames with no ready: second is dropped, one overrun pulse
        send_frame(8'h11, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
        expect_frame(8'h11, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
        idle(2 * bit_clk);
        send_frame(8'h22, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
        expect_frame(8'h22, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
        idle(2 * bit_clk);
        check_outputs("ovr11");
        check("ovr_once", 32'(m_ovr), 32'd1);

        // reset in the middle of bit 3 of a frame
        d = 8'hC3;
        rx_i = 1'b0;
        idle(bit_clk);
        for (int i = 0; i < 3; i++) begin
            rx_i = d[i];
            idle(bit_clk);
        end
        rx_i = d[3];
        idle(bit_clk / 2);
        rst_ni = 1'b0;
        #1;
        m_valid = 1'b0; m_data = '0; m_pe = 1'b0; m_fe = 1'b0;
        check("midrst_busy", 32'(busy_o), 32'd0);
        check("midrst_valid", 32'(valid_o), 32'd0);
        check("midrst_data", 32'(data_o), 32'd0);
        check("midrst_ovr", 32'(overrun_o), 32'd0);
        check("midrst_flags", 32'({parity_err_o, frame_err_o}), 32'd0);
        rx_i = 1'b1;
        idle(3);
        rst_ni = 1'b1;
        idle(20);
        check("postrst_busy", 32'(busy_o), 32'd0);
        send_frame(8'h3C, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
        expect_frame(8'h3C, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
        idle(bit_clk);
        check_outputs("rx3c");
        accept();

        // randomised frames, divisors, formats and consumer behaviour
        for (int n = 0; n < 24; n++) begin
            dv = int'($urandom_range(0, 2));
            div_i = DIV_W'(dv);
            bit_clk = OVS * (dv + 1);
            d  = 8'($urandom);
            pm = 2'($urandom_range(0, 3));
            s2 = 1'($urandom_range(0, 1));
            pb = 1'($urandom_range(0, 1));
            sa = ($urandom_range(0, 3) != 0);
            sb = ($urandom_range(0, 3) != 0);
            send_frame(d, pm, s2, pb, sa, sb);
            expect_frame(d, pm, s2, pb, sa, sb);
            idle(2 * bit_clk);
            check_outputs($sformatf("rnd%0d", n));
            if ($urandom_range(0, 1) == 1) accept();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/as_rx_cfg.md
AS_RX_CFG -- requirements
Module: as_rx_cfg

Interface
REQ-001 SHALL have parameter DATA_W, default 8, data bits per frame, legal range 5..9.
REQ-002 SHALL have parameter OVS, default 16, oversampling ticks per bit, even, minimum 4.
REQ-003 SHALL have parameter DIV_W, default 16, width of the baud divisor.
REQ-004 SHALL have port clk_i, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_ni, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port rx_i, input, 1 bit: asynchronous serial line, idle high.
REQ-007 SHALL have port div_i, input, DIV_W bits: clocks per oversample tick, minus 1.
REQ-008 SHALL have port parity_i, input, 2 bits: 00 none, 01 even, 10 odd, 11 treated as none.
REQ-009 SHALL have port stop2_i, input, 1 bit: 1 selects two stop bits.
REQ-010 SHALL have port ready_i, input, 1 bit: consumer accepts the current data.
REQ-011 SHALL have port data_o, output, DATA_W bits: received word.
REQ-012 SHALL have port valid_o, output, 1 bit: data_o and the error flags are valid.
REQ-013 SHALL have port parity_err_o, output, 1 bit: parity mismatch for the held word.
REQ-014 SHALL have port frame_err_o, output, 1 bit: a stop bit was sampled low for the held word.
REQ-015 SHALL have port overrun_o, output, 1 bit: one-cycle pulse when a frame is dropped.
REQ-016 SHALL have port busy_o, output, 1 bit: high whenever the FSM is not in IDLE.

Function
REQ-017 SHALL pass rx_i through a 2-flop synchroniser before any other use; both flops reset to 1.
REQ-018 SHALL generate a tick every div_i+1 clocks, with div_i=0 giving a tick every clock.
REQ-019 SHALL hold the tick divider at zero in IDLE and restart it on start detection.
REQ-020 SHALL use FSM states IDLE, START, DATA, PARITY, STOP.
REQ-021 SHALL move IDLE->START on a synchronised 1->0 transition.
REQ-022 SHALL latch parity_i and stop2_i at the IDLE->START transition and ignore later changes until the frame ends.
REQ-023 SHALL form each bit value as the majority of three samples taken at ticks OVS/2-1, OVS/2 and OVS/2+1 within the bit.
REQ-024 SHALL, in START, return to IDLE without any output if the majority sample is 1 (false start); otherwise go to DATA at the end of the bit.
REQ-025 SHALL, in DATA, shift in DATA_W bits LSB-first, using a bit counter that wraps at DATA_W-1.
REQ-026 SHALL then go to PARITY when parity is enabled, else to STOP.
REQ-027 SHALL, in PARITY, flag an error if the XOR of the data bits and the parity bit is not 0 (even mode) or not 1 (odd mode).
REQ-028 SHALL, in STOP, sample one stop bit or two (stop2), and flag frame error if any stop bit is 0.
REQ-029 SHALL complete the frame at the mid-sample of the last stop bit, then return to IDLE without waiting for the end of the bit.
REQ-030 SHALL, on completion, register data_o, parity_err_o and frame_err_o and assert valid_o on the next clock, if valid_o is low or ready_i is high in the completion cycle.
REQ-031 SHALL hold valid_o high, with data and flags stable, until a cycle with ready_i=1; valid_o SHALL clear in the next cycle unless a new completion coincides.
REQ-032 SHALL, on completion with valid_o=1 and ready_i=0, drop the new frame, keep the held word, and pulse overrun_o for one cycle.
REQ-033 SHALL on coincident ready_i=1 and completion load the new word with valid_o staying high and no overrun.
REQ-034 SHALL continue to the next frame regardless of the output handshake state, so the receiver never stalls.

Reset
REQ-035 SHALL, while rst_ni=0, immediately force: state IDLE; divider and counters 0; data_o 0; valid_o, parity_err_o, frame_err_o, overrun_o and busy_o 0.
REQ-036 SHALL discard any partial frame on reset; after release, reception begins only on a new falling edge.

Verification (DATA_W=8, OVS=16, div_i=0: 16 clocks per bit)
REQ-037 SHALL cover: frame 0xA5, no parity, 1 stop -> data_o=0xA5, valid_o=1, no errors, held until ready_i.
REQ-038 SHALL cover: even parity, data 0x03, parity bit 1 -> data_o=0x03, parity_err_o=1.
REQ-039 SHALL cover: stop2_i=1 with second stop bit 0, data 0x5A -> data_o=0x5A, frame_err_o=1.
REQ-040 SHALL cover: 4-clock low glitch on an idle line -> busy_o returns low, valid_o stays 0.
REQ-041 SHALL cover: frames 0x11 then 0x22, ready_i=0 -> data_o stays 0x11 and overrun_o pulses once.
REQ-042 SHALL cover: rst_ni pulsed low in the middle of bit 3 -> all outputs 0; a following frame 0x3C is received correctly.
